// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, opcode field, HALT opcode,
// fetch entry bundle and fetch FSM state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;

    localparam opcode_t HALT = 6'b111111;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    typedef enum logic {
        FB_FETCH,
        FB_HALTED
    } fb_state_e;

    function automatic word_t next_pc(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch buffer bundle: PC-side request, icache return, decode-side
// head entry and status. Modports: fb (buffer), pc, dec, tb.
interface fetch_buffer_if;
    import cpu_types_pkg::*;

    word_t pcaddr;
    logic  ihit;
    word_t iload;
    logic  iREN;
    word_t iaddr;
    logic  pc_en;
    logic  flush;
    logic  dec_stall;
    logic  dec_valid;
    word_t dec_instr;
    word_t dec_pc;
    word_t dec_npc;
    logic  halted;

    modport fb (
        input  pcaddr, ihit, iload, flush, dec_stall,
        output iREN, iaddr, pc_en, dec_valid,
        output dec_instr, dec_pc, dec_npc, halted
    );

    modport pc (
        output pcaddr,
        input  pc_en, halted
    );

    modport dec (
        output flush, dec_stall,
        input  dec_valid, dec_instr, dec_pc, dec_npc
    );

    modport tb (
        output pcaddr, ihit, iload, flush, dec_stall,
        input  iREN, iaddr, pc_en, dec_valid,
        input  dec_instr, dec_pc, dec_npc, halted
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetch entries with push/pop/clear.
// Ports: clk, rst_n, push_i, pop_i, clear_i, wdata_i -> rdata_o, count_o, full_o, empty_o.
module fetch_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic [CW-1:0] count_o,
    output logic         full_o,
    output logic         empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + AW'(1);
            if (pop_i)  rd_d = rd_q + AW'(1);
            if (push_i && !pop_i)
                cnt_d = cnt_q + CW'(1);
            else if (pop_i && !push_i)
                cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the head is only consumed while count != 0.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i)
            mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_buffer_unit.sv
// Fetch stage: requests pcaddr from icache, buffers hits, feeds decode.
// Ports: CLK, nRST, pcaddr, ihit, iload, flush, dec_stall -> iREN, iaddr, pc_en, dec_*, halted.
module fetch_buffer_unit
    import cpu_types_pkg::*;
#(
    parameter int      DEPTH   = 2,
    parameter opcode_t HALT_OP = HALT
) (
    input  logic  CLK,
    input  logic  nRST,
    input  word_t pcaddr,
    input  logic  ihit,
    input  word_t iload,
    output logic  iREN,
    output word_t iaddr,
    output logic  pc_en,
    input  logic  flush,
    input  logic  dec_stall,
    output logic  dec_valid,
    output word_t dec_instr,
    output word_t dec_pc,
    output word_t dec_npc,
    output logic  halted
);

    localparam int CW = $clog2(DEPTH + 1);

    fb_state_e     state_q, state_d;
    fetch_entry_t  head;
    fetch_entry_t  wentry;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          space;

    assign iaddr     = pcaddr;
    assign dec_valid = !empty;
    assign pop       = dec_valid && !dec_stall && !flush;
    assign space     = !full || pop;

    // Gated by nRST so an in-flight hit is dropped the moment reset asserts.
    assign iREN  = nRST && (state_q == FB_FETCH) && space && !flush;
    assign push  = iREN && ihit;
    assign pc_en = push;

    assign wentry.pc    = pcaddr;
    assign wentry.instr = iload;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (nRST),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush),
        .wdata_i (wentry),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= FB_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        halted  = 1'b0;
        unique case (state_q)
            FB_FETCH: begin
                if (push && iload[31:26] == HALT_OP)
                    state_d = FB_HALTED;
            end
            FB_HALTED: begin
                halted = 1'b1;
                // A flush means the HALT sat on a squashed path.
                if (flush)
                    state_d = FB_FETCH;
            end
            default: state_d = FB_FETCH;
        endcase
    end

    assign dec_instr = dec_valid ? head.instr       : '0;
    assign dec_pc    = dec_valid ? head.pc          : '0;
    assign dec_npc   = dec_valid ? next_pc(head.pc) : '0;

    count_bound_a: assert property (
        @(posedge CLK) disable iff (!nRST) count <= CW'(DEPTH)
    );

endmodule

// File: tb/tb_fetch_buffer_unit.sv
// Directed bench for fetch_buffer_unit.
// Drives inputs 1ns after posedge, samples 1ns later.
module tb_fetch_buffer_unit;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    word_t pcaddr;
    logic  ihit;
    word_t iload;
    logic  iREN;
    word_t iaddr;
    logic  pc_en;
    logic  flush;
    logic  dec_stall;
    logic  dec_valid;
    word_t dec_instr;
    word_t dec_pc;
    word_t dec_npc;
    logic  halted;

    int checks   = 0;
    int failures = 0;
    int pc_en_cnt;

    always #5 CLK = ~CLK;

    fetch_buffer_unit #(
        .DEPTH   (2),
        .HALT_OP (6'b111111)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .pcaddr    (pcaddr),
        .ihit      (ihit),
        .iload     (iload),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .pc_en     (pc_en),
        .flush     (flush),
        .dec_stall (dec_stall),
        .dec_valid (dec_valid),
        .dec_instr (dec_instr),
        .dec_pc    (dec_pc),
        .dec_npc   (dec_npc),
        .halted    (halted)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input word_t pa, input logic hit, input word_t ld);
        pcaddr = pa;
        ihit   = hit;
        iload  = ld;
    endtask

    initial begin
        nRST      = 1'b0;
        flush     = 1'b0;
        dec_stall = 1'b0;
        drive(32'h0000_1234, 1'b1, 32'h2001_0001);
        step();
        step();
        #1;
        check("rst_iren", 32'(iREN), 32'd0);
        check("rst_pcen", 32'(pc_en), 32'd0);
        check("rst_valid", 32'(dec_valid), 32'd0);
        check("rst_instr", dec_instr, 32'h0);
        check("rst_pc", dec_pc, 32'h0);
        check("rst_npc", dec_npc, 32'h0);
        check("rst_halted", 32'(halted), 32'd0);
        check("iaddr", iaddr, 32'h0000_1234);

        // steady hits
        nRST = 1'b1;
        drive(32'h0, 1'b1, 32'h2001_0001);
        #1;
        check("s0_pcen", 32'(pc_en), 32'd1);
        check("s0_valid", 32'(dec_valid), 32'd0);
        step();
        drive(32'h4, 1'b1, 32'h2002_0002);
        #1;
        check("s1_pcen", 32'(pc_en), 32'd1);
        check("s1_valid", 32'(dec_valid), 32'd1);
        check("s1_pc", dec_pc, 32'h0);
        check("s1_npc", dec_npc, 32'h4);
        check("s1_instr", dec_instr, 32'h2001_0001);
        step();
        drive(32'h8, 1'b1, 32'h2003_0003);
        #1;
        check("s2_pcen", 32'(pc_en), 32'd1);
        check("s2_pc", dec_pc, 32'h4);
        check("s2_npc", dec_npc, 32'h8);
        step();
        drive(32'hC, 1'b0, 32'h0);
        #1;
        check("s3_pc", dec_pc, 32'h8);
        check("s3_npc", dec_npc, 32'hC);
        check("s3_instr", dec_instr, 32'h2003_0003);
        step();
        #1;
        check("s4_valid", 32'(dec_valid), 32'd0);

        // fill on stall: 4 hit cycles, only 2 captured
        dec_stall = 1'b1;
        pc_en_cnt = 0;
        drive(32'h20, 1'b1, 32'h2004_0004);
        #1;
        pc_en_cnt += int'(pc_en);
        step();
        drive(32'h24, 1'b1, 32'h2005_0005);
        #1;
        pc_en_cnt += int'(pc_en);
        step();
        drive(32'h28, 1'b1, 32'h2006_0006);
        #1;
        pc_en_cnt += int'(pc_en);
        check("full_iren", 32'(iREN), 32'd0);
        check("full_pcen", 32'(pc_en), 32'd0);
        step();
        #1;
        pc_en_cnt += int'(pc_en);
        check("fill_pushes", 32'(pc_en_cnt), 32'd2);
        check("full_hold_pc", dec_pc, 32'h20);

        // release stall: pop and push at full in the same cycle
        dec_stall = 1'b0;
        #1;
        check("rel_iren", 32'(iREN), 32'd1);
        check("rel_pcen", 32'(pc_en), 32'd1);
        check("rel_pc", dec_pc, 32'h20);
        check("rel_instr", dec_instr, 32'h2004_0004);
        step();
        drive(32'h2C, 1'b1, 32'h2007_0007);
        #1;
        check("wrap1_pc", dec_pc, 32'h24);
        check("wrap1_pcen", 32'(pc_en), 32'd1);
        step();
        #1;
        check("wrap2_pc", dec_pc, 32'h28);
        check("wrap2_instr", dec_instr, 32'h2006_0006);

        // flush with full buffer and a hit
        drive(32'h30, 1'b1, 32'h2000_0030);
        flush = 1'b1;
        #1;
        check("fl_pcen", 32'(pc_en), 32'd0);
        check("fl_iren", 32'(iREN), 32'd0);
        step();
        flush = 1'b0;
        drive(32'h40, 1'b1, 32'h2008_0008);
        #1;
        check("fl_valid", 32'(dec_valid), 32'd0);
        check("fl_new_pcen", 32'(pc_en), 32'd1);
        step();
        drive(32'h44, 1'b0, 32'h0);
        #1;
        check("fl_new_pc", dec_pc, 32'h40);
        check("fl_new_instr", dec_instr, 32'h2008_0008);
        step();

        // halt
        drive(32'h10, 1'b1, 32'hFC00_0000);
        #1;
        check("h_pcen", 32'(pc_en), 32'd1);
        check("h_halted0", 32'(halted), 32'd0);
        step();
        drive(32'h14, 1'b1, 32'h2009_0009);
        #1;
        check("h_halted1", 32'(halted), 32'd1);
        check("h_iren", 32'(iREN), 32'd0);
        check("h_pcen1", 32'(pc_en), 32'd0);
        check("h_pc", dec_pc, 32'h10);
        check("h_instr", dec_instr, 32'hFC00_0000);
        step();
        #1;
        check("h_drained", 32'(dec_valid), 32'd0);
        check("h_pcen2", 32'(pc_en), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(32'h80, 1'b1, 32'h200A_000A);
        #1;
        check("hf_halted", 32'(halted), 32'd0);
        check("hf_pcen", 32'(pc_en), 32'd1);
        step();

        // async reset with one entry buffered
        dec_stall = 1'b1;
        drive(32'h84, 1'b1, 32'h200B_000B);
        #1;
        check("ar_valid1", 32'(dec_valid), 32'd1);
        check("ar_pc1", dec_pc, 32'h80);
        nRST = 1'b0;
        #1;
        check("ar_valid0", 32'(dec_valid), 32'd0);
        check("ar_iren", 32'(iREN), 32'd0);
        check("ar_pcen", 32'(pc_en), 32'd0);
        step();
        nRST      = 1'b1;
        dec_stall = 1'b0;

        // npc 32-bit wrap
        drive(32'hFFFF_FFFC, 1'b1, 32'h200C_000C);
        #1;
        check("wr_pcen", 32'(pc_en), 32'd1);
        step();
        drive(32'h0, 1'b0, 32'h0);
        #1;
        check("wr_pc", dec_pc, 32'hFFFF_FFFC);
        check("wr_npc", dec_npc, 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_buffer_unit.md
Name: fetch_buffer_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Presents pcaddr to instruction memory and captures returned instructions into a small FIFO. Tells the PC when to advance and feeds {pc, npc, instr} to decode.
- Decouples icache hits from decode stalls.
- Handles redirect flushes and stops fetching after a HALT.

Parameters:
- DEPTH, 2, FIFO entries (power of two, >=2)
- HALT_OP, 6'b111111, opcode that stops fetch

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- pcaddr  in  32  current PC (word_t) from program counter
- ihit  in  1  icache hit this cycle; iload valid
- iload  in  32  instruction returned for iaddr
- iREN  out  1  instruction read enable
- iaddr  out  32  instruction address (= pcaddr)
- pc_en  out  1  PC advance strobe (replaces raw ihit at the PC)
- flush  in  1  redirect (branch/jump/JR taken); squash buffered instrs
- dec_stall  in  1  decode cannot accept this cycle
- dec_valid  out  1  head entry valid
- dec_instr  out  32  head instruction
- dec_pc  out  32  head instruction address
- dec_npc  out  32  head pc + 4
- halted  out  1  fetch has stopped on HALT

Behaviour:
- Reset (async, nRST=0): FIFO empty (count=0, rd/wr pointers 0), state FETCH. Outputs: iREN=0, pc_en=0, dec_valid=0, dec_instr/dec_pc/dec_npc=0, halted=0.
- iaddr = pcaddr combinationally, always.
- pop = dec_valid & !dec_stall & !flush.
- space = (count < DEPTH) | pop.
- iREN = (state==FETCH) & space & !flush.
- push = iREN & ihit.
- pc_en = push. The PC never advances on an ihit that was not captured.
- Push writes {pcaddr, iload} at wr pointer. Pointers wrap mod DEPTH.
- count' = count + push - pop. Simultaneous push and pop at full: count stays DEPTH.
- Head outputs are combinational from the rd-pointer entry. dec_npc = dec_pc + 4, 32-bit wrap (0xFFFFFFFC -> 0x00000000).
- dec_valid = (count != 0). Zero-latency bypass is not used: a pushed instruction appears at decode the cycle after ihit.
- State machine:
  - FETCH -> HALTED when push & iload[31:26]==HALT_OP. The HALT is stored; iREN drops from the next cycle.
  - HALTED: iREN=0, pc_en=0, halted=1. Buffered entries (including the HALT) still drain to decode normally.
  - HALTED -> FETCH on flush, because the HALT was on a squashed path. halted=0 the next cycle.
- flush has priority over push and pop in the same cycle:
  - next cycle count=0 and pointers equal;
  - ihit that cycle is ignored (iREN=0, pc_en=0);
  - the PC loads its redirect target via its own path.
- dec_stall with count==DEPTH: iREN=0, pc_en=0, FIFO holds contents unchanged.
- Reset mid-operation: immediate return to reset state; any in-flight ihit is discarded.

Decomposition:
- cpu_types_pkg (existing): word_t, opcode_t, HALT opcode constant. Add fetch_entry_t (struct: word_t pc, word_t instr).
- Add interface fetch_buffer_if with modports fb / pc / dec / tb, matching existing interface style.
- One sub-module: fetch_fifo (parameterised DEPTH, fetch_entry_t storage, push/pop/clear, count, full/empty).
- Top level holds the FSM and handshake logic.

Test Plan:
- Reset then steady hits:
  - Stimulus: nRST low 2 cycles, then pcaddr=0x0,0x4,0x8 with ihit=1, iload=0x20010001,0x20020002,0x20030003, dec_stall=0.
  - Response: pc_en=1 each cycle; dec_valid=1 from the cycle after first ihit; dec_pc 0x0,0x4,0x8 in order; dec_npc 0x4,0x8,0xC.
- Fill on stall:
  - Stimulus: dec_stall=1, ihit=1 for 4 cycles.
  - Response: exactly 2 pushes (pc_en high twice), then iREN=0, pc_en=0.
  - Release stall: entries pop in order; iREN reasserts the same cycle as the first pop.
- Full push and pop:
  - Stimulus: count=2, dec_stall=0, ihit=1.
  - Response: pc_en=1, count stays 2, ordering preserved across pointer wrap.
- Flush priority:
  - Stimulus: count=2, flush=1 with ihit=1.
  - Response: pc_en=0, dec_valid=0 next cycle. New fetch at redirected pcaddr=0x40 appears with dec_pc=0x40.
- Halt:
  - Stimulus: iload=0xFC000000 at pcaddr=0x10.
  - Response: halted=1 and iREN=0 from next cycle; HALT delivered to decode with dec_pc=0x10; no further pc_en.
  - Flush while halted: halted=0, fetch resumes.
- Async reset mid-stream:
  - Stimulus: nRST low between clock edges with count=1.
  - Response: dec_valid=0 and iREN=0 immediately, without waiting for a CLK edge.
